sprite_rom_arbiter: RTL

//  - Shares one synchronous sprite/background ROM among N pixel fetch units (background + object displays).
//  - Each requester posts an address; a round-robin arbiter issues one ROM read per cycle.
//  - Returned data is routed back to the issuing requester with a fixed, known latency.
//  - Sits between the displayObj/displayBg fetch logic and the single block-memory instance.

---
 rtl/sprite_arb_pkg.sv | 32 +++
 rtl/sprite_rom_arbiter_rr_pick.sv | 41 ++++
 rtl/sprite_rom_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/sprite_arb_pkg.sv
// ============================================================================
// Module      : sprite_arb_pkg
// Description : Shared defaults, index-width helper and tag type for the
//               sprite ROM arbiter family.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sprite_arb_pkg;

  localparam int ADDR_W_DEF = 19;
  localparam int DATA_W_DEF = 12;
  localparam int N_REQ_DEF  = 4;
  localparam int N_REQ_MAX  = 8;
  localparam int IDX_MAX_W  = $clog2(N_REQ_MAX);

  // Index width for n requesters; never narrower than one bit
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int IDX_W = idx_w(N_REQ_DEF);

  // One entry of the return-routing pipe
  typedef struct packed {
    logic                 valid;
    logic [IDX_MAX_W-1:0] idx;
  } tag_t;

endpackage

`default_nettype wire

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Returns the first set
//               request bit at or after ptr (wrapping), as one-hot and index.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int N_REQ = sprite_arb_pkg::N_REQ_DEF,
  parameter int IDX_W = sprite_arb_pkg::IDX_W
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic found;

  // Scan candidates ptr, ptr+1, ... (mod N_REQ) and take the first requesting one
  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (!found && req[j] && (j == ((int'(ptr) + k) % N_REQ))) begin
          found     = 1'b1;
          onehot[j] = 1'b1;
          idx       = IDX_W'(j);
        end
      end
    end
    any = |req;
  end

endmodule

`default_nettype wire

// File: rtl/sprite_rom_arbiter.sv
// ============================================================================
// Module      : sprite_rom_arbiter
// Description : Shares one synchronous ROM among N_REQ fetch units. One read
//               issued per cycle (round-robin), data routed back to the
//               issuer ROM_LAT+1 edges after its request was sampled.
// Options     : SPRITE_ARB_PRIO0_EN - requester 0 gets strict priority,
//               the rest rotate among themselves.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_rom_arbiter
  import sprite_arb_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ROM_LAT = 1
) (
  input  logic                    clk,
  input  logic                    clrn,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]       rdata,
  output logic                    rom_en,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [DATA_W-1:0]       rom_dout
);

  localparam int IDX_W = idx_w(N_REQ);

  logic [IDX_W-1:0]  ptr;
  logic [N_REQ-1:0]  pick_req;
  logic [N_REQ-1:0]  pick_onehot;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;
  logic              win_zero;
  logic [N_REQ-1:0]  win_onehot;
  logic [IDX_W-1:0]  win_idx;
  logic              win_any;
  logic [IDX_W-1:0]  ptr_nxt;
  logic [ADDR_W-1:0] sel_addr;
  tag_t              pipe [ROM_LAT+1];

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req    (pick_req),
    .ptr    (ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

`ifdef SPRITE_ARB_PRIO0_EN
  // Requester 0 bypasses the rotation; the picker only sees the others
  always_comb begin
    pick_req    = req;
    pick_req[0] = 1'b0;
    win_zero    = req[0];
  end
`else
  // Every requester takes part in the rotation
  always_comb begin
    pick_req = req;
    win_zero = 1'b0;
  end
`endif

  // Final winner, next pointer and the winner's address
  always_comb begin
    win_onehot = pick_onehot;
    win_idx    = pick_idx;
    win_any    = pick_any;
    ptr_nxt    = ptr;
    if (win_zero) begin
      win_onehot    = '0;
      win_onehot[0] = 1'b1;
      win_idx       = '0;
      win_any       = 1'b1;
    end else if (pick_any) begin
      ptr_nxt = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
    end
    sel_addr = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (win_onehot[j]) sel_addr = req_addr[j*ADDR_W +: ADDR_W];
    end
  end

  // Issue register: grant pulse, ROM command and rotation pointer
  always_ff @(posedge clk) begin
    if (!clrn) begin
      gnt      <= '0;
      rom_en   <= 1'b0;
      rom_addr <= '0;
      ptr      <= '0;
    end else begin
      gnt    <= win_onehot;
      rom_en <= win_any;
      if (win_any) rom_addr <= sel_addr;
      ptr    <= ptr_nxt;
    end
  end

  // Tag pipe: stage k holds the tag of the read issued k edges ago
  always_ff @(posedge clk) begin
    if (!clrn) begin
      for (int k = 0; k <= ROM_LAT; k++) pipe[k] <= '0;
    end else begin
      pipe[0].valid <= win_any;
      pipe[0].idx   <= IDX_MAX_W'(win_idx);
      for (int k = 1; k <= ROM_LAT; k++) pipe[k] <= pipe[k-1];
    end
  end

  // Return stage: ROM data is valid alongside the oldest tag; rdata holds otherwise
  always_ff @(posedge clk) begin
    if (!clrn) begin
      rvalid <= '0;
      rdata  <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        rvalid[i] <= pipe[ROM_LAT].valid && (pipe[ROM_LAT].idx == IDX_MAX_W'(i));
      end
      if (pipe[ROM_LAT].valid) rdata <= rom_dout;
    end
  end

endmodule

`default_nettype wire
